// File: rtl/sram_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sram_fifo_pkg
//   Shared constants and types for the SRAM-backed FIFO controller.
//   - Macro geometry (16 x 128, 4-bit addresses).
//   - Output-queue depth and occupancy widths.
//   - Port-group structs for the macro write and read ports.
//   - A debug struct exposing the controller bookkeeping for checkers.
//   - oq_wrap: modulo-3 index helper for the output queue.
// -----------------------------------------------------------------------------
package sram_fifo_pkg;

    localparam int SRAM_DATA_W = 128;
    localparam int SRAM_DEPTH  = 16;
    localparam int SRAM_ADDR_W = 4;

    localparam int OQ_DEPTH = 3;
    localparam int OQ_CNT_W = 2;
    localparam int CNT_W    = 5;

    // Macro write port group: active-low enable, address, data.
    typedef struct packed {
        logic                   web;
        logic [SRAM_ADDR_W-1:0] aa;
        logic [SRAM_DATA_W-1:0] d;
    } sram_wr_t;

    // Macro read port group: active-low enable, address.
    typedef struct packed {
        logic                   reb;
        logic [SRAM_ADDR_W-1:0] ab;
    } sram_rd_t;

    // Internal bookkeeping made visible for assertions and benches.
    typedef struct packed {
        logic [SRAM_ADDR_W-1:0] wptr;
        logic [SRAM_ADDR_W-1:0] rptr;
        logic [CNT_W-1:0]       scnt;
        logic                   inflight;
        logic [OQ_CNT_W-1:0]    oq_cnt;
    } fifo_dbg_t;

    // Reduce a small sum (0..4) to an output-queue slot index (0..2).
    function automatic logic [OQ_CNT_W-1:0] oq_wrap(input logic [OQ_CNT_W:0] v);
        return (v >= 3'd3) ? 2'(v - 3'd3) : v[OQ_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/sram_fifo_ctrl_if.sv
// -----------------------------------------------------------------------------
// sram_fifo_ctrl_if
//   Enqueue and dequeue valid/ready handshakes of the SRAM FIFO.
//   A transfer happens on a clock edge where valid and ready are both high;
//   the sender holds valid and data stable until that edge, and valid never
//   depends combinationally on ready.
//   Modports:
//     master : producer/consumer side (drives in_valid/in_data/out_ready)
//     slave  : FIFO side (drives in_ready/out_valid/out_data)
// -----------------------------------------------------------------------------
interface sram_fifo_ctrl_if
    import sram_fifo_pkg::*;
#(
    parameter int DATA_W = SRAM_DATA_W
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/sram_fifo_outq.sv
// -----------------------------------------------------------------------------
// sram_fifo_outq
//   Three-entry register FIFO holding data returned by the SRAM macro.
//   Ports:
//     clock, reset   : clock, asynchronous active-high reset
//     flush          : synchronous clear (wins over push/pop)
//     push/push_data : write one entry (caller guarantees room)
//     pop            : drop the head (caller guarantees cnt != 0)
//     cnt            : occupancy 0..3
//     head           : oldest entry, meaningful when cnt != 0
// -----------------------------------------------------------------------------
module sram_fifo_outq
    import sram_fifo_pkg::*;
#(
    parameter int W = SRAM_DATA_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                flush,
    input  logic                push,
    input  logic [W-1:0]        push_data,
    input  logic                pop,
    output logic [OQ_CNT_W-1:0] cnt,
    output logic [W-1:0]        head
);

    logic [W-1:0]        mem [OQ_DEPTH];
    logic [OQ_CNT_W-1:0] hd;
    logic [OQ_CNT_W-1:0] tail;

    // Tail is head + occupancy; with push and pop together the write slot is
    // never the head because pop implies cnt != 0.
    assign tail = oq_wrap({1'b0, hd} + {1'b0, cnt});
    assign head = mem[hd];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hd  <= '0;
            cnt <= '0;
        end else if (flush) begin
            hd  <= '0;
            cnt <= '0;
        end else begin
            if (pop) begin
                hd <= oq_wrap({1'b0, hd} + 3'd1);
            end
            if (push && !pop) begin
                cnt <= cnt + 2'd1;
            end else if (pop && !push) begin
                cnt <= cnt - 2'd1;
            end
        end
    end

    // Storage needs no reset: entries are only read when counted.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[tail] <= push_data;
        end
    end

endmodule

// File: rtl/sram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// sram_fifo_ctrl
//   Turns a 16x128 two-port SRAM macro (one write port, one synchronous read
//   port with one-cycle latency) into a valid/ready FIFO. Read data is caught
//   in a 3-entry register queue so the output runs at one entry per cycle.
//   Ports:
//     clock, reset : sole clock, asynchronous active-high reset
//     flush        : synchronous clear of all contents
//     bus          : enqueue (in_*) and dequeue (out_*) handshakes
//     count        : SRAM entries + in-flight read + output queue (0..19)
//     sram_web/aa/d: macro write port (enable active-low)
//     sram_reb/ab  : macro read port (enable active-low)
//     sram_q       : macro read data, valid the cycle after sram_reb low
//     dbg          : pointers and occupancy bookkeeping
// -----------------------------------------------------------------------------
module sram_fifo_ctrl
    import sram_fifo_pkg::*;
#(
    parameter int DATA_W = SRAM_DATA_W,
    parameter int DEPTH  = SRAM_DEPTH,
    parameter int ADDR_W = SRAM_ADDR_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                flush,
    sram_fifo_ctrl_if.slave     bus,
    output logic [CNT_W-1:0]    count,
    output logic                sram_web,
    output logic [ADDR_W-1:0]   sram_aa,
    output logic [DATA_W-1:0]   sram_d,
    output logic                sram_reb,
    output logic [ADDR_W-1:0]   sram_ab,
    input  logic [DATA_W-1:0]   sram_q,
    output fifo_dbg_t           dbg
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ADDR_W-1:0]   wptr;
    logic [ADDR_W-1:0]   rptr;
    logic [CNT_W-1:0]    scnt;
    logic                inflight;
    logic [OQ_CNT_W-1:0] oq_cnt;
    logic [DATA_W-1:0]   oq_head;

    logic     wr;
    logic     rd;
    logic     pop;
    sram_wr_t wr_port;
    sram_rd_t rd_port;

    // in_ready depends on registers only, never on out_ready.
    assign bus.in_ready = !flush && (scnt != FULL_CNT);

    // Reset gating keeps the macro idle while reset is asserted, even if
    // in_valid is high.
    assign wr = bus.in_valid && bus.in_ready && !reset;

    // Issue only when the returning word is guaranteed a queue slot. An
    // entry written this cycle is not yet in scnt, so it is never read on
    // the same edge that writes it.
    assign rd = !reset && !flush && (scnt != '0) &&
                (({1'b0, oq_cnt} + {2'b0, inflight}) < 3'(OQ_DEPTH));

    assign bus.out_valid = !flush && (oq_cnt != '0);
    assign bus.out_data  = oq_head;
    assign pop           = bus.out_valid && bus.out_ready;

    always_comb begin
        wr_port     = '0;
        wr_port.web = !wr;
        wr_port.aa  = wptr;
        wr_port.d   = bus.in_data;
        rd_port     = '0;
        rd_port.reb = !rd;
        rd_port.ab  = rptr;
    end

    assign sram_web = wr_port.web;
    assign sram_aa  = wr_port.aa;
    assign sram_d   = wr_port.d;
    assign sram_reb = rd_port.reb;
    assign sram_ab  = rd_port.ab;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            scnt     <= '0;
            inflight <= 1'b0;
        end else if (flush) begin
            // Clearing inflight drops the word returning next cycle.
            wptr     <= '0;
            rptr     <= '0;
            scnt     <= '0;
            inflight <= 1'b0;
        end else begin
            if (wr) begin
                wptr <= wptr + ADDR_W'(1);
            end
            if (rd) begin
                rptr <= rptr + ADDR_W'(1);
            end
            inflight <= rd;
            if (wr && !rd) begin
                scnt <= scnt + CNT_W'(1);
            end else if (rd && !wr) begin
                scnt <= scnt - CNT_W'(1);
            end
        end
    end

    sram_fifo_outq #(
        .W (DATA_W)
    ) u_outq (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .push      (inflight),
        .push_data (sram_q),
        .pop       (pop),
        .cnt       (oq_cnt),
        .head      (oq_head)
    );

    assign count = scnt + CNT_W'(inflight) + CNT_W'(oq_cnt);

    always_comb begin
        dbg          = '0;
        dbg.wptr     = wptr;
        dbg.rptr     = rptr;
        dbg.scnt     = scnt;
        dbg.inflight = inflight;
        dbg.oq_cnt   = oq_cnt;
    end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_fifo_ctrl
//   Directed bench for sram_fifo_ctrl with a behavioural SRAM macro model.
//   Drivers push expected words into exp_q on accept; a negedge monitor pops
//   and compares on every output handshake.
// -----------------------------------------------------------------------------
module tb_sram_fifo_ctrl;
    import sram_fifo_pkg::*;

    localparam int W = SRAM_DATA_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic flush;
    always #5 clk = ~clk;

    logic [CNT_W-1:0]       count;
    logic                   sram_web;
    logic [SRAM_ADDR_W-1:0] sram_aa;
    logic [W-1:0]           sram_d;
    logic                   sram_reb;
    logic [SRAM_ADDR_W-1:0] sram_ab;
    logic [W-1:0]           sram_q;
    fifo_dbg_t              dbg;

    sram_fifo_ctrl_if bus ();

    sram_fifo_ctrl dut (
        .clock    (clk),
        .reset    (rst),
        .flush    (flush),
        .bus      (bus),
        .count    (count),
        .sram_web (sram_web),
        .sram_aa  (sram_aa),
        .sram_d   (sram_d),
        .sram_reb (sram_reb),
        .sram_ab  (sram_ab),
        .sram_q   (sram_q),
        .dbg      (dbg)
    );

    // SRAM macro model: garbage on sram_q whenever no read was issued.
    logic [W-1:0] mem [SRAM_DEPTH];
    always @(posedge clk) begin
        if (!sram_web) mem[sram_aa] <= sram_d;
        if (!sram_reb) sram_q <= mem[sram_ab];
        else           sram_q <= {$urandom, $urandom, $urandom, $urandom};
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    int           tests_run = 0;
    int           fails     = 0;
    logic [W-1:0] exp_q [$];
    logic [W-1:0] mon_exp;
    int           pops      = 0;
    int           first_pop = -1;
    int           last_pop  = -1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        tests_run++;
        fails++;
        $display("FAIL %s: event did not occur as required (t=%0t)", name, $time);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("oq_room", 1'({1'b0, dbg.oq_cnt} + {2'b0, dbg.inflight} <= 3'd3), 1'b1);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_out");
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("out_data", bus.out_data, mon_exp);
                end
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
                pops++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] d);
        bit ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back(d);
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!ok) fail_now("send_timeout");
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) begin
            @(posedge clk);
        end
        #1;
        if (exp_q.size() != 0) fail_now("drain_timeout");
        step();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        bit done;
        int c0;

        rst = 1'b1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        #3;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_count", count, 5'd0);
        check("rst_web", sram_web, 1'b1);
        check("rst_reb", sram_reb, 1'b1);
        check("rst_aa", sram_aa, 4'd0);
        check("rst_ab", sram_ab, 4'd0);
        check("rst_in_ready", bus.in_ready, 1'b1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // --- single entry latency ---
        step();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = 128'hA5;
        @(negedge clk);
        check("t1_in_ready", bus.in_ready, 1'b1);
        check("t1_web", sram_web, 1'b0);
        check("t1_aa", sram_aa, 4'd0);
        check("t1_d", sram_d, 128'hA5);
        exp_q.push_back(128'hA5);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        check("t1_reb_e1", sram_reb, 1'b0);
        check("t1_ab_e1", sram_ab, 4'd0);
        check("t1_valid_e1", bus.out_valid, 1'b0);
        check("t1_count_e1", count, 5'd1);
        @(negedge clk);
        check("t1_valid_e2", bus.out_valid, 1'b0);
        check("t1_inflight_e2", dbg.inflight, 1'b1);
        check("t1_reb_e2", sram_reb, 1'b1);
        @(negedge clk);
        check("t1_valid_e3", bus.out_valid, 1'b1);
        check("t1_count_e3", count, 5'd1);
        @(negedge clk);
        check("t1_valid_e4", bus.out_valid, 1'b0);
        check("t1_count_e4", count, 5'd0);
        step();

        // --- fill to 19 with out_ready low ---
        bus.out_ready = 1'b0;
        for (int i = 0; i < 19; i++) send(W'(i));
        @(negedge clk);
        check("t2_in_ready", bus.in_ready, 1'b0);
        check("t2_count", count, 5'd19);
        check("t2_scnt", dbg.scnt, 5'd16);
        check("t2_oq_cnt", dbg.oq_cnt, 2'd3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t2_no_issue", sram_reb, 1'b1);
        end
        step();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            check("t2_drain_valid", bus.out_valid, 1'b1);
            if (i == 0) begin
                check("t2_reb_c0", sram_reb, 1'b1);
                check("t2_in_ready_c0", bus.in_ready, 1'b0);
            end
            if (i == 1) begin
                check("t2_reb_c1", sram_reb, 1'b0);
                check("t2_in_ready_c1", bus.in_ready, 1'b0);
            end
            if (i == 2) check("t2_in_ready_c2", bus.in_ready, 1'b1);
        end
        step();
        check("t2_count_end", count, 5'd0);
        check("t2_exp_empty", 32'(exp_q.size()), 32'd0);

        // --- 40-entry stream, pointers wrap twice ---
        flush = 1'b1;
        step();
        flush = 1'b0;
        pops = 0;
        first_pop = -1;
        c0 = cyc;
        for (int i = 0; i < 40; i++) send(W'(32'h3000 + i));
        check("t3_in_rate", 32'(cyc - c0), 32'd40);
        wait_drain(100);
        check("t3_pops", 32'(pops), 32'd40);
        check("t3_out_rate", 32'(last_pop - first_pop), 32'd39);
        check("t3_wptr", dbg.wptr, 4'd8);
        check("t3_rptr", dbg.rptr, 4'd8);
        check("t3_count", count, 5'd0);

        // --- random backpressure, 200 entries ---
        pops = 0;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 200; i++) send(W'(32'h4000 + i));
                done = 1'b1;
            end
            begin
                while (!done) begin
                    bus.out_ready = 1'($urandom_range(0, 1));
                    step();
                end
            end
        join
        bus.out_ready = 1'b1;
        wait_drain(600);
        check("t4_pops", 32'(pops), 32'd200);
        check("t4_count", count, 5'd0);

        // --- flush with a read in flight ---
        bus.out_ready = 1'b0;
        for (int i = 0; i < 11; i++) send(W'(32'h5000 + i));
        repeat (3) step();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("t5_issue", sram_reb, 1'b0);
        step();
        check("t5_inflight", dbg.inflight, 1'b1);
        check("t5_count_pre", count, 5'd10);
        flush = 1'b1;
        exp_q.delete();
        bus.in_valid = 1'b1;
        bus.in_data = 128'hDEAD;
        @(negedge clk);
        check("t5_fl_in_ready", bus.in_ready, 1'b0);
        check("t5_fl_out_valid", bus.out_valid, 1'b0);
        check("t5_fl_web", sram_web, 1'b1);
        check("t5_fl_reb", sram_reb, 1'b1);
        step();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("t5_count_post", count, 5'd0);
        check("t5_valid_post", bus.out_valid, 1'b0);
        check("t5_oq_post", dbg.oq_cnt, 2'd0);
        step();
        bus.out_ready = 1'b1;
        send(128'h1);
        wait_drain(20);
        check("t5_count_end", count, 5'd0);

        // --- asynchronous reset mid-operation ---
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(W'(32'h6000 + i));
        bus.in_valid = 1'b1;
        bus.in_data = 128'h7;
        #2 rst = 1'b1;
        #1;
        check("t6_count", count, 5'd0);
        check("t6_out_valid", bus.out_valid, 1'b0);
        check("t6_web", sram_web, 1'b1);
        check("t6_reb", sram_reb, 1'b1);
        check("t6_in_ready", bus.in_ready, 1'b1);
        check("t6_wptr", dbg.wptr, 4'd0);
        exp_q.delete();
        bus.in_valid = 1'b0;
        step();
        rst = 1'b0;
        step();
        check("t6_count_after", count, 5'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
